// File: rtl/wash_pkg.sv
// Package wash_pkg: shared definitions for the wash program sequencer.
//   state_t      - sequencer state encoding
//   DISP_*       - bit positions inside the one-hot state_display bus
//   DEF_*_SEC    - default phase lengths in seconds
//   display_of() - maps a state plus the paused flag to the display bus
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

  localparam int DISP_W     = 6;
  localparam int DISP_FILL  = 0;
  localparam int DISP_AGIT  = 1;  // wash or rinse agitation
  localparam int DISP_DRAIN = 2;
  localparam int DISP_SPIN  = 3;
  localparam int DISP_DONE  = 4;
  localparam int DISP_FLAG  = 5;  // paused or fault

  localparam int unsigned DEF_WASH_SEC     = 20;
  localparam int unsigned DEF_RINSE_SEC    = 10;
  localparam int unsigned DEF_SPIN_SEC     = 15;
  localparam int unsigned DEF_ALARM_SEC    = 5;
  localparam int unsigned DEF_FILL_TMO_SEC = 30;
  localparam int unsigned DEF_RINSE_CNT    = 2;

  // Phase bits stay set while paused; the flag bit is added on top.
  function automatic logic [DISP_W-1:0] display_of(input state_t st, input logic paused);
    logic [DISP_W-1:0] d;
    d = '0;
    case (st)
      ST_FILL:  d[DISP_FILL]  = 1'b1;
      ST_WASH:  d[DISP_AGIT]  = 1'b1;
      ST_DRAIN: d[DISP_DRAIN] = 1'b1;
      ST_SPIN:  d[DISP_SPIN]  = 1'b1;
      ST_DONE:  d[DISP_DONE]  = 1'b1;
      ST_FAULT: d[DISP_FLAG]  = 1'b1;
      default:  d = '0;
    endcase
    if (paused) d[DISP_FLAG] = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/wash_program_sequencer_phase_timer.sv
// phase_timer: TW-bit seconds down-counter for one sequencer phase.
//   clk, reset  - system clock, synchronous active-high reset
//   load        - load load_val (takes priority over counting)
//   load_val    - phase length in seconds
//   tick        - 1 Hz strobe
//   hold        - freeze the count (pause, or a higher-priority event this cycle)
//   expire      - combinational: this tick consumes the last second (count==1)
//   count       - seconds remaining, registered
// The counter never goes below zero, so an idle timer simply sits at 0.
module phase_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  input  logic          hold,
  output logic          expire,
  output logic [TW-1:0] count
);

  assign expire = tick && !hold && (count == TW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && !hold && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

endmodule

// File: rtl/wash_program_sequencer.sv
// wash_program_sequencer: runs fill, wash, drain, RINSE_CNT x (fill, rinse,
// drain), spin and a done alarm, with fill/drain timeouts, pause and stop.
//   clk, reset            - system clock, synchronous active-high reset
//   tick_1hz              - one-clk strobe per second
//   start, pause, stop    - one-clk key pulses
//   waterfull, waterempty - tub level sensors
//   water, wash, drain, dewater, alarm - actuator drives (registered)
//   state_display         - one-hot phase bus, bit 5 = paused or fault
//   time_left             - seconds remaining in the current phase
//   rinse_left            - rinse cycles still to run
//   dbg_state, dbg_paused - current FSM state and paused flag for observation
// Every output is a flop loaded from the next-state values, so outputs move on
// the same edge as the state register they describe.
module wash_program_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned WASH_SEC     = DEF_WASH_SEC,
  parameter int unsigned RINSE_SEC    = DEF_RINSE_SEC,
  parameter int unsigned SPIN_SEC     = DEF_SPIN_SEC,
  parameter int unsigned ALARM_SEC    = DEF_ALARM_SEC,
  parameter int unsigned FILL_TMO_SEC = DEF_FILL_TMO_SEC,
  parameter int unsigned RINSE_CNT    = DEF_RINSE_CNT,
  parameter int unsigned TW           = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              waterfull,
  input  logic              waterempty,
  output logic              water,
  output logic              wash,
  output logic              drain,
  output logic              dewater,
  output logic              alarm,
  output logic [DISP_W-1:0] state_display,
  output logic [TW-1:0]     time_left,
  output logic [2:0]        rinse_left,
  output state_t            dbg_state,
  output logic              dbg_paused
);

  localparam logic [TW-1:0] LEN_WASH  = TW'(WASH_SEC);
  localparam logic [TW-1:0] LEN_RINSE = TW'(RINSE_SEC);
  localparam logic [TW-1:0] LEN_SPIN  = TW'(SPIN_SEC);
  localparam logic [TW-1:0] LEN_ALARM = TW'(ALARM_SEC);
  localparam logic [TW-1:0] LEN_TMO   = TW'(FILL_TMO_SEC);

  state_t        state, state_n;
  logic          paused, paused_n;
  logic          abort, abort_n;          // drain ends in IDLE instead of SPIN
  logic          first_pass, first_pass_n; // agitation uses WASH_SEC, not RINSE_SEC
  logic [2:0]    rinse_n;
  logic          running;
  logic          tmr_load, tmr_hold, tmr_expire;
  logic [TW-1:0] tmr_val;

  assign running = (state == ST_FILL) || (state == ST_WASH) ||
                   (state == ST_DRAIN) || (state == ST_SPIN);

  // A stop or pause in a running phase outranks the tick, so the tick must
  // not consume a second in that cycle either.
  assign tmr_hold = paused || (running && (stop || pause));

  phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick_1hz),
    .hold     (tmr_hold),
    .expire   (tmr_expire),
    .count    (time_left)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      paused     <= 1'b0;
      abort      <= 1'b0;
      first_pass <= 1'b0;
    end else begin
      state      <= state_n;
      paused     <= paused_n;
      abort      <= abort_n;
      first_pass <= first_pass_n;
    end
  end

  always_comb begin
    state_n      = state;
    paused_n     = paused;
    abort_n      = abort;
    first_pass_n = first_pass;
    rinse_n      = rinse_left;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n      = ST_FILL;
          rinse_n      = 3'(RINSE_CNT);
          first_pass_n = 1'b1;
          abort_n      = 1'b0;
          paused_n     = 1'b0;
          tmr_load     = 1'b1;
          tmr_val      = LEN_TMO;
        end
      end

      ST_FILL, ST_WASH, ST_DRAIN, ST_SPIN: begin
        if (stop) begin
          abort_n = 1'b1;
          if (state != ST_DRAIN) begin
            state_n  = ST_DRAIN;
            paused_n = 1'b0;
            rinse_n  = '0;
            tmr_load = 1'b1;
            tmr_val  = LEN_TMO;
          end
        end else if (pause) begin
          paused_n = !paused;
        end else if (!paused) begin
          if (state == ST_FILL) begin
            if (waterfull) begin
              state_n  = ST_WASH;
              tmr_load = 1'b1;
              tmr_val  = first_pass ? LEN_WASH : LEN_RINSE;
            end else if (tmr_expire) begin
              state_n  = ST_FAULT;
              rinse_n  = '0;
              abort_n  = 1'b0;
              tmr_load = 1'b1;
            end
          end else if (state == ST_WASH) begin
            if (tmr_expire) begin
              state_n      = ST_DRAIN;
              first_pass_n = 1'b0;
              tmr_load     = 1'b1;
              tmr_val      = LEN_TMO;
            end
          end else if (state == ST_DRAIN) begin
            if (waterempty) begin
              tmr_load = 1'b1;
              if (abort) begin
                state_n = ST_IDLE;
                abort_n = 1'b0;
                rinse_n = '0;
              end else if (rinse_left != '0) begin
                state_n = ST_FILL;
                rinse_n = rinse_left - 3'd1;
                tmr_val = LEN_TMO;
              end else begin
                state_n = ST_SPIN;
                tmr_val = LEN_SPIN;
              end
            end else if (tmr_expire) begin
              state_n  = ST_FAULT;
              rinse_n  = '0;
              abort_n  = 1'b0;
              tmr_load = 1'b1;
            end
          end else begin
            if (tmr_expire) begin
              state_n  = ST_DONE;
              tmr_load = 1'b1;
              tmr_val  = LEN_ALARM;
            end
          end
        end
      end

      ST_DONE: begin
        if (stop || tmr_expire) begin
          state_n  = ST_IDLE;
          tmr_load = 1'b1;
        end
      end

      ST_FAULT: begin
        if (start) begin
          state_n  = ST_IDLE;
          tmr_load = 1'b1;
        end
      end

      default: begin
        state_n  = ST_IDLE;
        paused_n = 1'b0;
        abort_n  = 1'b0;
        rinse_n  = '0;
        tmr_load = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      water         <= 1'b0;
      wash          <= 1'b0;
      drain         <= 1'b0;
      dewater       <= 1'b0;
      alarm         <= 1'b0;
      state_display <= '0;
      rinse_left    <= '0;
    end else begin
      water         <= (state_n == ST_FILL) && !paused_n;
      wash          <= (state_n == ST_WASH) && !paused_n;
      drain         <= ((state_n == ST_DRAIN) || (state_n == ST_SPIN)) && !paused_n;
      dewater       <= (state_n == ST_SPIN) && !paused_n;
      alarm         <= (state_n == ST_DONE) || (state_n == ST_FAULT);
      state_display <= display_of(state_n, paused_n);
      rinse_left    <= rinse_n;
    end
  end

  assign dbg_state  = state;
  assign dbg_paused = paused;

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Bench for wash_program_sequencer. The reference model keeps the remaining
// wash program as a queue of (phase, length) steps built when start is seen;
// rinse_left is simply the number of fills still queued.
module tb_wash_program_sequencer;

  localparam int P_WASH = 3, P_RINSE = 2, P_SPIN = 2, P_ALARM = 1;
  localparam int P_TMO = 4, P_RCNT = 2, P_TW = 8;

  localparam int PH_IDLE = 0, PH_FILL = 1, PH_AGIT = 2, PH_DRAIN = 3;
  localparam int PH_SPIN = 4, PH_DONE = 5, PH_FAULT = 6;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, tick_1hz, start, pause, stop, waterfull, waterempty;
  logic water, wash, drain, dewater, alarm;
  logic [5:0] state_display;
  logic [P_TW-1:0] time_left;
  logic [2:0] rinse_left;
  wash_pkg::state_t dbg_state;
  logic dbg_paused;

  wash_program_sequencer #(
    .WASH_SEC(P_WASH), .RINSE_SEC(P_RINSE), .SPIN_SEC(P_SPIN), .ALARM_SEC(P_ALARM),
    .FILL_TMO_SEC(P_TMO), .RINSE_CNT(P_RCNT), .TW(P_TW)
  ) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .start(start), .pause(pause),
    .stop(stop), .waterfull(waterfull), .waterempty(waterempty),
    .water(water), .wash(wash), .drain(drain), .dewater(dewater), .alarm(alarm),
    .state_display(state_display), .time_left(time_left), .rinse_left(rinse_left),
    .dbg_state(dbg_state), .dbg_paused(dbg_paused)
  );

  // reference model
  typedef struct { int ph; int len; } step_t;
  step_t plan[$];
  int m_ph = PH_IDLE, m_left = 0;
  bit m_paused = 0, m_abort = 0;

  function automatic int m_rinse();
    int n = 0;
    foreach (plan[i]) if (plan[i].ph == PH_FILL) n++;
    return n;
  endfunction

  function automatic void m_advance();
    step_t s;
    if (plan.size() == 0) begin
      m_ph = PH_IDLE; m_left = 0;
    end else begin
      s = plan.pop_front();
      m_ph = s.ph; m_left = s.len;
    end
  endfunction

  function automatic void m_fault();
    plan.delete(); m_ph = PH_FAULT; m_left = 0; m_abort = 0;
  endfunction

  function automatic void m_build();
    plan.delete();
    plan.push_back('{PH_FILL, P_TMO});
    plan.push_back('{PH_AGIT, P_WASH});
    plan.push_back('{PH_DRAIN, P_TMO});
    for (int r = 0; r < P_RCNT; r++) begin
      plan.push_back('{PH_FILL, P_TMO});
      plan.push_back('{PH_AGIT, P_RINSE});
      plan.push_back('{PH_DRAIN, P_TMO});
    end
    plan.push_back('{PH_SPIN, P_SPIN});
    plan.push_back('{PH_DONE, P_ALARM});
  endfunction

  function automatic void m_step(bit r, bit s, bit p, bit sp, bit t, bit wf, bit we);
    if (r) begin
      plan.delete(); m_ph = PH_IDLE; m_left = 0; m_paused = 0; m_abort = 0;
      return;
    end
    case (m_ph)
      PH_IDLE: if (s) begin m_build(); m_abort = 0; m_paused = 0; m_advance(); end
      PH_FILL, PH_AGIT, PH_DRAIN, PH_SPIN: begin
        if (sp) begin
          m_abort = 1;
          if (m_ph != PH_DRAIN) begin
            plan.delete(); m_ph = PH_DRAIN; m_left = P_TMO; m_paused = 0;
          end
        end else if (p) begin
          m_paused = !m_paused;
        end else if (!m_paused) begin
          if (m_ph == PH_FILL && wf) m_advance();
          else if (m_ph == PH_DRAIN && we) begin
            if (m_abort) begin plan.delete(); m_abort = 0; end
            m_advance();
          end else if (t) begin
            if (m_left == 1) begin
              if (m_ph == PH_FILL || m_ph == PH_DRAIN) m_fault();
              else m_advance();
            end else m_left--;
          end
        end
      end
      PH_DONE: begin
        if (sp) begin plan.delete(); m_ph = PH_IDLE; m_left = 0; end
        else if (t) begin
          if (m_left == 1) m_advance(); else m_left--;
        end
      end
      PH_FAULT: if (s) begin m_ph = PH_IDLE; m_left = 0; end
      default: ;
    endcase
  endfunction

  function automatic logic [21:0] m_out();
    logic [5:0] d;
    logic run;
    run = !m_paused;
    d = '0;
    if (m_ph >= PH_FILL && m_ph <= PH_DONE) d[m_ph-1] = 1'b1;
    if (m_paused || m_ph == PH_FAULT) d[5] = 1'b1;
    return {(m_ph == PH_FILL) && run, (m_ph == PH_AGIT) && run,
            (m_ph == PH_DRAIN || m_ph == PH_SPIN) && run, (m_ph == PH_SPIN) && run,
            (m_ph == PH_DONE || m_ph == PH_FAULT), d, 8'(m_left), 3'(m_rinse())};
  endfunction

  // scoreboard
  logic [21:0] exp_q[$];
  string name_q[$];
  int n_compared = 0, n_mismatched = 0;
  string cur_name = "reset";

  function automatic string fmt(logic [21:0] v);
    return $sformatf("water=%b wash=%b drain=%b dewater=%b alarm=%b disp=%b time_left=%0d rinse_left=%0d",
                     v[21], v[20], v[19], v[18], v[17], v[16:11], v[10:3], v[2:0]);
  endfunction

  always @(negedge clk) begin
    logic [21:0] e, got;
    string nm;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      got = {water, wash, drain, dewater, alarm, state_display, time_left, rinse_left};
      n_compared++;
      if (got !== e) begin
        n_mismatched++;
        $display("FAIL %s @%0t: got %s required %s", nm, $time, fmt(got), fmt(e));
      end
    end
  end

  // driver tasks
  logic wf_lvl = 0, we_lvl = 0;
  bit rnd_sensors = 0;

  task automatic step(input bit r, input bit s, input bit p, input bit sp, input bit t);
    if (rnd_sensors) begin
      wf_lvl = ($urandom_range(0, 3) == 0);
      we_lvl = ($urandom_range(0, 3) == 0);
    end
    reset = r; start = s; pause = p; stop = sp; tick_1hz = t;
    waterfull = wf_lvl; waterempty = we_lvl;
    @(posedge clk);
    m_step(r, s, p, sp, t, wf_lvl, we_lvl);
    exp_q.push_back(m_out());
    name_q.push_back(cur_name);
    #1;
    reset = 0; start = 0; pause = 0; stop = 0; tick_1hz = 0;
  endtask

  function automatic bit rnd_tick();
    return ($urandom_range(0, 2) == 0);
  endfunction

  // run with random ticks until the model reaches phase ph (and time_left
  // equals left_req when left_req >= 0)
  task automatic run_to(input int ph, input int left_req, input int budget);
    int n = 0;
    while (!(m_ph == ph && (left_req < 0 || m_left == left_req)) && n < budget) begin
      step(0, 0, 0, 0, rnd_tick());
      n++;
    end
    n_compared++;
    if (!(m_ph == ph && (left_req < 0 || m_left == left_req))) begin
      n_mismatched++;
      $display("FAIL %s run_to: got phase %0d after %0d cycles, required phase %0d", cur_name, m_ph, n, ph);
    end
  endtask

  initial begin
    reset = 1; start = 0; pause = 0; stop = 0; tick_1hz = 0; waterfull = 0; waterempty = 0;

    cur_name = "reset";
    repeat (3) step(1, 0, 0, 0, rnd_tick());
    repeat (4) step(0, 0, 1, 1, rnd_tick());   // pause/stop ignored in IDLE

    cur_name = "full_program";
    wf_lvl = 1; we_lvl = 1;
    step(0, 1, 0, 0, 0);
    run_to(PH_IDLE, -1, 400);

    cur_name = "fill_timeout";
    wf_lvl = 0; we_lvl = 0;
    step(0, 1, 0, 0, 0);
    run_to(PH_FAULT, -1, 200);
    repeat (3) step(0, 0, 1, 1, 1);            // pause/stop ignored in FAULT
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    cur_name = "pause_in_wash";
    wf_lvl = 1; we_lvl = 1;
    step(0, 1, 0, 0, 0);
    run_to(PH_AGIT, 2, 200);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    run_to(PH_IDLE, -1, 400);

    cur_name = "stop_in_spin";
    step(0, 1, 0, 0, 0);
    run_to(PH_SPIN, -1, 400);
    we_lvl = 0;
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    we_lvl = 1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    cur_name = "stop_pause_tick";
    step(0, 1, 0, 0, 0);
    run_to(PH_AGIT, -1, 200);
    we_lvl = 0;
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    we_lvl = 1;
    run_to(PH_IDLE, -1, 200);

    cur_name = "stop_in_done";
    step(0, 1, 0, 0, 0);
    run_to(PH_DONE, -1, 400);
    step(0, 0, 1, 0, 0);                       // pause ignored in DONE
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    cur_name = "reset_in_spin";
    step(0, 1, 0, 0, 0);
    run_to(PH_SPIN, -1, 400);
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, rnd_tick());

    cur_name = "random";
    rnd_sensors = 1;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0), rnd_tick());
    end

    repeat (3) @(negedge clk);
    #1;
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL drain_queue: got %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
